// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous ROM and registers inst/pc/valid for decode.
// Optional misaligned-redirect trap guarded by `INST_FETCH_MISALIGN_EN (adds fetch_err, halts fetch when set).
module inst_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              ADDR_W   = 6,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst_code,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid
`ifdef INST_FETCH_MISALIGN_EN
  ,
  output logic              fetch_err
`endif
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_HALT
  } action_e;

  action_e         action;
  logic [PC_W-1:0] f_pc;
  logic            f_valid;
  logic            halt;
  logic [PC_W-1:0] target_pc;
  logic [PC_W-1:0] pc_inc;

  // Low two bits of the target are dropped so pc stays word aligned.
  assign target_pc = redirect_pc & ~PC_W'(3);
  assign pc_inc    = pc + PC_W'(4);

`ifdef INST_FETCH_MISALIGN_EN
  logic misaligned;
  assign misaligned = redirect & (redirect_pc[1:0] != 2'b00);
  assign halt       = fetch_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_err <= 1'b0;
    else      fetch_err <= fetch_err | misaligned;
  end
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    // NOTE: default first so every path assigns action and no latch is inferred.
    action = ACT_ADVANCE;
    if (halt)          action = ACT_HALT;
    else if (redirect) action = ACT_REDIRECT;
    else if (stall)    action = ACT_HOLD;
  end

  // While stalled the ROM re-reads the in-flight word so imem_data is still valid on release.
  assign imem_addr = (stall && !redirect) ? f_pc[ADDR_W+1:2] : pc[ADDR_W+1:2];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: async reset clears every register here; there is no storage array to exclude.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      f_pc       <= RESET_PC;
      f_valid    <= 1'b0;
      inst_code  <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      unique case (action)
        ACT_ADVANCE: begin
          pc         <= pc_inc;
          f_pc       <= pc;
          f_valid    <= 1'b1;
          inst_code  <= imem_data;
          inst_pc    <= f_pc;
          inst_valid <= f_valid;
        end
        ACT_REDIRECT: begin
          pc         <= target_pc;
          f_valid    <= 1'b0;
          inst_valid <= 1'b0;
        end
        ACT_HALT: begin
          f_valid    <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          // ACT_HOLD: decode is not ready, everything keeps its value.
        end
      endcase
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Parametrised instruction-fetch stage, successor to the free-running PC+ROM fetch.
- Owns the program counter and drives a synchronous instruction ROM (1-cycle read latency).
- Adds stall, branch/jump redirect with pipeline flush, and a registered instruction/PC/valid output to the decode stage.
- All logic on the rising edge of `clk`.

Parameters:
- PC_W, 32: program-counter width in bits.
- ADDR_W, 6: ROM word-address width. ROM depth is 2^ADDR_W words.
- INST_W, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset. Must be 4-byte aligned.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-low (0 = reset).
- stall  in  1: decode not ready; hold all fetch state.
- redirect  in  1: branch/jump taken this cycle.
- redirect_pc  in  PC_W: target byte address.
- imem_addr  out  ADDR_W: ROM word address (combinational).
- imem_data  in  INST_W: ROM read data, valid 1 cycle after its address.
- pc  out  PC_W: current fetch PC.
- inst_code  out  INST_W: registered instruction to decode.
- inst_pc  out  PC_W: byte address of inst_code.
- inst_valid  out  1: inst_code/inst_pc are valid.

Behaviour:
- Internal state: pc, f_pc (address in flight to ROM), f_valid.
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, f_pc=RESET_PC, f_valid=0.
  - inst_code=0, inst_pc=0, inst_valid=0.
- imem_addr:
  - = f_pc[ADDR_W+1:2] when stall=1 and redirect=0. This re-reads the in-flight word so imem_data stays correct.
  - = pc[ADDR_W+1:2] otherwise.
- Advance (redirect=0, stall=0), each rising edge:
  - inst_code<=imem_data, inst_pc<=f_pc, inst_valid<=f_valid.
  - f_pc<=pc, f_valid<=1.
  - pc<=pc+4.
- Stall (stall=1, redirect=0): pc, f_pc, f_valid, inst_code, inst_pc, inst_valid all hold.
- Redirect (redirect=1) has priority over stall:
  - pc<=redirect_pc, f_valid<=0, inst_valid<=0. f_pc and inst_code are don't-care.
  - The target instruction appears with inst_valid=1 after the 2nd rising edge following the redirect edge.
  - A stall asserted during those cycles extends this latency 1:1.
- After reset release: mem[RESET_PC] with inst_valid=1 after the 2nd rising edge. Then one instruction per unstalled cycle, in order, with no gaps.
- Arithmetic and alignment:
  - pc+4 wraps modulo 2^PC_W.
  - Addresses beyond ROM depth alias via the dropped upper bits; no error is raised.
  - pc[1:0] is always 00. redirect_pc[1:0] is ignored and forced to 00 when loaded.
- Reset mid-stall or mid-redirect: the asynchronous reset wins immediately and all state returns to reset values.

Optional Feature:
- Macro: INST_FETCH_MISALIGN_EN.
- When defined:
  - Adds output port fetch_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=00 sets fetch_err (sticky until reset). The redirect is still taken, with low bits cleared.
  - While fetch_err=1: inst_valid<=0 and pc holds, i.e. fetch halts.
- When not defined: no fetch_err port; low bits are silently cleared; fetch never halts.

Test Plan:
- Reset, then 6 unstalled cycles with ROM word n = 0x1000_0000+n:
  - inst_valid rises after the 2nd edge.
  - inst_code sequence is 0x10000000, 0x10000001, …
  - inst_pc sequence is 0, 4, 8, …
- Stall for 3 cycles while inst_pc=8:
  - inst_code/inst_pc/inst_valid held for 3 cycles.
  - After release, next inst_pc=0xC; no skipped or duplicated word.
- redirect=1, redirect_pc=0x40 while inst_pc=0x10:
  - inst_valid=0 for 2 cycles.
  - Then inst_pc=0x40, inst_code=mem[16], then 0x44.
- redirect and stall asserted together:
  - Redirect taken, pc=target.
  - With stall held for 2 more cycles, the target appears 2 cycles later than the unstalled case.
- ADDR_W=6, redirect_pc=0xFC:
  - Fetches mem[63] at inst_pc=0xFC.
  - Then inst_pc=0x100 with inst_code=mem[0] (alias).
- rst pulsed low mid-stream:
  - All outputs 0 immediately, pc=RESET_PC.
  - With INST_FETCH_MISALIGN_EN defined, a redirect to 0x42 sets fetch_err=1, stops inst_valid, and the pulse clears fetch_err to 0.
